// File: rtl/dlfloat_pkg.sv
// Shared DLFloat constants, serializer state encoding and the FIFO entry layout.
// The nan/zero flags travel with each word so the byte stream never re-decodes it.
package dlfloat_pkg;

  localparam int DLF_W      = 16;
  localparam int DLF_EXP_W  = 6;
  localparam int DLF_MANT_W = 9;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } ser_state_e;

  typedef struct packed {
    logic [DLF_W-1:0] data;
    logic             nan;
    logic             zero;
  } dlf_entry_t;

  function automatic dlf_entry_t dlf_make_entry(input logic [DLF_W-1:0] w);
    dlf_entry_t e;
    e.data = w;
    e.nan  = (w == DLF_NAN);
    e.zero = (w == DLF_ZERO);
    return e;
  endfunction

endpackage

// File: rtl/dlfloat_sync_fifo.sv
// Single-clock FIFO with occupancy counter; full/empty derive from the count.
// Writes while full and reads while empty are ignored.
module dlfloat_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dlfloat_result_serializer.sv
// Buffers DLFloat MAC results and streams each as two bytes over a valid/ready port,
// flagging NaN/zero words and latching a sticky error when a result is dropped.
module dlfloat_result_serializer
  import dlfloat_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  input  logic [15:0]                res_data,
  output logic                       res_ready,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  output logic                       byte_last,
  input  logic                       byte_ready,
  output logic                       word_nan,
  output logic                       word_zero,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       drop_err
);

  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  ser_state_e  state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic        byte_last_q, byte_last_d;
  logic        nan_q, nan_d;
  logic        zero_q, zero_d;
  logic        drop_err_q, drop_err_d;

  logic        fifo_full, fifo_empty, fifo_push, pop;
  dlf_entry_t  push_entry, pop_entry;

  assign push_entry = dlf_make_entry(res_data);
  assign fifo_push  = res_valid & ~fifo_full;
  assign res_ready  = ~fifo_full;

  dlfloat_sync_fifo #(
    .WIDTH ($bits(dlf_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    nan_d        = nan_q;
    zero_d       = zero_q;
    drop_err_d   = drop_err_q | (res_valid & fifo_full);
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        pop = ~fifo_empty;
      end
      BYTE0: begin
        if (byte_ready) begin
          byte_out_d  = second_byte(word_q);
          byte_last_d = 1'b1;
          state_d     = BYTE1;
        end
      end
      BYTE1: begin
        if (byte_ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            byte_out_d   = '0;
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
            nan_d        = 1'b0;
            zero_d       = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading a new word is shared by the IDLE start and the back-to-back BYTE1 case
    if (pop) begin
      word_d       = pop_entry.data;
      byte_out_d   = first_byte(pop_entry.data);
      byte_valid_d = 1'b1;
      byte_last_d  = 1'b0;
      nan_d        = pop_entry.nan;
      zero_d       = pop_entry.zero;
      state_d      = BYTE0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      nan_q        <= 1'b0;
      zero_q       <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      nan_q        <= nan_d;
      zero_q       <= zero_d;
      drop_err_q   <= drop_err_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign word_nan   = nan_q;
  assign word_zero  = zero_q;
  assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_dlfloat_result_serializer.sv
// Directed and randomized checks of the result serializer against a queue-based
// model of words held and bytes still owed for the word being streamed.
module tb_dlfloat_result_serializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        word_nan;
  logic        word_zero;
  logic [2:0]  fifo_count;
  logic        drop_err;

  dlfloat_result_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .word_nan   (word_nan),
    .word_zero  (word_zero),
    .fifo_count (fifo_count),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  // Model: words waiting, word being sent, and bytes of it not yet accepted
  logic [15:0] m_fifo[$];
  logic [15:0] m_cur;
  int          m_left;
  bit          m_drop;
  logic [7:0]  acc[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
  endtask

  task automatic model_step(input bit rs, input bit v, input logic [15:0] d, input bit r);
    bit room;
    if (rs) begin
      m_fifo.delete();
      m_left = 0;
      m_drop = 1'b0;
      return;
    end
    room = (m_fifo.size() < DEPTH);
    if (m_left > 0 && r) m_left--;
    if (m_left == 0 && m_fifo.size() > 0) begin
      m_cur  = m_fifo.pop_front();
      m_left = 2;
    end
    if (v && room) m_fifo.push_back(d);
    else if (v)    m_drop = 1'b1;
  endtask

  task automatic compare_all();
    bit vld;
    vld = (m_left > 0);
    chk("byte_valid", {15'd0, byte_valid}, {15'd0, vld});
    chk("byte_last", {15'd0, byte_last}, {15'd0, (m_left == 1)});
    chk("word_nan", {15'd0, word_nan}, {15'd0, (vld && m_cur == 16'hFFFF)});
    chk("word_zero", {15'd0, word_zero}, {15'd0, (vld && m_cur == 16'h0000)});
    chk("fifo_count", {13'd0, fifo_count}, 16'(m_fifo.size()));
    chk("res_ready", {15'd0, res_ready}, {15'd0, (m_fifo.size() < DEPTH)});
    chk("drop_err", {15'd0, drop_err}, {15'd0, m_drop});
    if (vld) chk("byte_out", {8'd0, byte_out}, {8'd0, (m_left == 2) ? m_cur[15:8] : m_cur[7:0]});
  endtask

  task automatic cyc(input bit rs, input bit v, input logic [15:0] d, input bit r);
    rst        = rs;
    res_valid  = v;
    res_data   = d;
    byte_ready = r;
    if (!rs && byte_valid === 1'b1 && r) acc.push_back(byte_out);
    @(posedge clk);
    model_step(rs, v, d, r);
    cyc_n++;
    #1;
    compare_all();
  endtask

  initial begin
    logic [15:0] rd;
    rst = 1'b1; res_valid = 1'b0; res_data = '0; byte_ready = 1'b0;
    m_left = 0; m_drop = 1'b0; m_cur = '0;

    // Reset held two cycles with a result offered
    cyc(1'b1, 1'b1, 16'h1111, 1'b0);
    cyc(1'b1, 1'b1, 16'h2222, 1'b0);
    chk("rst_byte_out", {8'd0, byte_out}, 16'h0000);
    chk("rst_count", {13'd0, fifo_count}, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("rel_res_ready", {15'd0, res_ready}, 16'h0001);

    // Single word, two-cycle latency, MSB first
    cyc(1'b0, 1'b1, 16'h3E40, 1'b1);
    chk("lat_not_yet", {15'd0, byte_valid}, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("w1_byte0", {8'd0, byte_out}, 16'h003E);
    chk("w1_last0", {15'd0, byte_last}, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("w1_byte1", {8'd0, byte_out}, 16'h0040);
    chk("w1_last1", {15'd0, byte_last}, 16'h0001);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);

    // NaN then zero, back to back
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b1);
    cyc(1'b0, 1'b1, 16'h0000, 1'b1);
    chk("nan_b0", {15'd0, word_nan}, 16'h0001);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("nan_b1", {15'd0, word_nan}, 16'h0001);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("zero_nogap", {14'd0, byte_valid, word_zero}, 16'h0003);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);

    // Fill while stalled, then overflow
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h1000 + 16'(i), 1'b0);
    chk("full_count", {13'd0, fifo_count}, 16'h0004);
    chk("full_ready", {15'd0, res_ready}, 16'h0000);
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("drop_set", {15'd0, drop_err}, 16'h0001);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);

    // Alternating backpressure
    acc.delete();
    cyc(1'b0, 1'b1, 16'h3E40, 1'b1);
    cyc(1'b0, 1'b1, 16'h4180, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 16'h0000, (i % 2) == 0);
    chk("stall_nbytes", 16'(acc.size()), 16'd4);
    if (acc.size() == 4) begin
      chk("stall_ord0", {8'd0, acc[0]}, 16'h003E);
      chk("stall_ord1", {8'd0, acc[1]}, 16'h0040);
      chk("stall_ord2", {8'd0, acc[2]}, 16'h0041);
      chk("stall_ord3", {8'd0, acc[3]}, 16'h0080);
    end

    // Reset mid-word
    cyc(1'b0, 1'b1, 16'h1234, 1'b0);
    cyc(1'b0, 1'b1, 16'h5678, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("midrst_valid", {15'd0, byte_valid}, 16'h0000);
    chk("midrst_count", {13'd0, fifo_count}, 16'h0000);
    cyc(1'b0, 1'b1, 16'hA5C3, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("postrst_b0", {8'd0, byte_out}, 16'h00A5);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("postrst_b1", {8'd0, byte_out}, 16'h00C3);

    // Random traffic with occasional special encodings and resets
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(7))
        0:       rd = 16'hFFFF;
        1:       rd = 16'h0000;
        default: rd = 16'($urandom);
      endcase
      cyc($urandom_range(99) == 0, $urandom_range(9) < 6, rd, $urandom_range(3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
